relu_drain_ctrl: RTL and testbench
==================================

// Module: relu_drain_ctrl
// PURPOSE
//  Drains one tile of BUF_WIDTH-bit accumulator results out of the psum buffer.
//  Sequences each result through the shared 1-cycle ReLU/requant unit.
//  Packs PACK requantised bytes per output word and hands words to the output
//  feature-map writer over a valid/ready interface. Sits between the PE-array
//  psum buffer and the ofm buffer; started once per tile by the layer sequencer.
// PARAMETERS
//  BUF_WIDTH   26  accumulator/psum width (ReLU input width)
//  OUT_WIDTH   8   ReLU output width per element
//  ADDR_WIDTH  10  psum buffer address width
//  LEN_WIDTH   11  element-count width
//  PACK        4   elements per output word
// PORTS
//  clk          in   1                clock, rising edge
//  rst_n        in   1                reset, asynchronous, active-low
//  start        in   1                1-cycle pulse: begin a tile (ignored while busy)
//  base_addr    in   ADDR_WIDTH       first psum address, latched on accepted start
//  len          in   LEN_WIDTH        element count, latched on accepted start
//  busy         out  1                high from accepted start until done
//  done         out  1                1-cycle pulse, tile finished
//  psum_rd_en   out  1                psum buffer read strobe
//  psum_rd_addr out  ADDR_WIDTH       psum read address
//  psum_rd_data in   BUF_WIDTH        read data, valid exactly 1 cycle after psum_rd_en
//  relu_ifm     out  BUF_WIDTH        to ReLU input = psum_rd_data (combinational pass)
//  relu_ofm     in   OUT_WIDTH        ReLU result, valid 1 cycle after relu_ifm
//  out_valid    out  1                output word valid
//  out_ready    in   1                downstream accepts word
//  out_data     out  PACK*OUT_WIDTH   packed word; element k of the word in lane k
//                                     (lane 0 = bits [OUT_WIDTH-1:0])
//  out_last     out  1                qualifies final word of tile
// BEHAVIOUR
//  - Reset: all outputs 0. FSM=IDLE. Counters, lane register, in-flight tracker cleared.
//  - Reset is async: asserting mid-tile aborts it immediately. No done. Words not yet
//    accepted are dropped.
//  - FSM IDLE->RUN on start && len!=0. IDLE->DONE on start && len==0.
//    RUN->DRAIN when len reads issued.
//    DRAIN->DONE when in_flight==0, lanes empty, and the last word is handshaked.
//    DONE->IDLE after 1 cycle (done=1 in DONE). busy=1 in RUN/DRAIN/DONE.
//  - start while busy has no effect. base_addr/len are sampled only on accepted start.
//  - Read i (0..len-1) uses addr = base_addr+i mod 2^ADDR_WIDTH (wraps, no error).
//  - Element pipeline: rd_en at cycle t -> psum_rd_data at t+1 -> relu_ofm at t+2,
//    then the byte is captured into the next free lane.
//  - The block tracks these stages with its own 2-bit valid shift. It never
//    inspects the data value.
//  - Credit rule: issue a read in a cycle only if in_flight + lanes_filled < PACK.
//    in_flight counts reads in stages t+1..t+2.
//  - Word transfer: when lanes_filled==PACK, or when the tile's final element has
//    been captured, the lane register moves to the out register in the cycle that
//    the out register is empty or out_ready=1. Lanes then clear.
//  - Unfilled lanes of a partial final word are 0.
//  - out_last=1 only with the final word of the tile.
//  - out_valid && !out_ready: out_data/out_last held stable. Neither changes until
//    the handshake.
//  - Elements are never lost, duplicated or reordered.
//  - psum_rd_en is never asserted in IDLE/DRAIN/DONE.
//  - done pulses the cycle after the final out_valid&&out_ready.
// TESTING
//  1 Ordering and requant, 1-word tile.
//    base=0, len=4, psum={26'h3FFFFFB, 26'h000200, 26'h0001FF, 26'h0FFFFFF}, out_ready=1
//    -> one word 32'h7F010100 with out_last=1, then 1-cycle done.
//  2 Partial final word.
//    len=6, elements 1..6 (values 1<<9 .. 6<<9)
//    -> word0=32'h04030201 (last=0), word1=32'h00000605 (last=1), done after word1.
//  3 Backpressure.
//    len=16, out_ready=0 for 20 cycles after first out_valid
//    -> out_data stable throughout; no psum_rd_en once credit exhausted;
//    all 4 words correct after release.
//  4 Empty tile.
//    len=0 -> busy 1 cycle, done pulse the cycle after start; no psum_rd_en, no out_valid.
//  5 Address wrap and ignored start.
//    base=10'h3FE, len=4 -> addrs 3FE,3FF,000,001.
//    Second start pulsed mid-tile -> ignored, exactly 1 word.
//  6 Reset mid-tile.
//    rst_n low during RUN -> all outputs 0 at once, no done.
//    New start after release completes normally.

Source files
------------

// File: rtl/relu_drain_ctrl.sv
// Drains one tile of psum results through the shared ReLU/requant unit and
// packs PACK requantised bytes per output word onto a valid/ready stream.
module relu_drain_ctrl #(
    parameter int unsigned BUF_WIDTH  = 26,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 11,
    parameter int unsigned PACK       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      done,
    output logic                      psum_rd_en,
    output logic [ADDR_WIDTH-1:0]     psum_rd_addr,
    input  logic [BUF_WIDTH-1:0]      psum_rd_data,
    output logic [BUF_WIDTH-1:0]      relu_ifm,
    input  logic [OUT_WIDTH-1:0]      relu_ofm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK*OUT_WIDTH-1:0] out_data,
    output logic                      out_last
);

    localparam int unsigned FillW = $clog2(PACK + 1);
    localparam logic [FillW-1:0] PackF = FillW'(PACK);
    localparam logic [FillW:0]   PackU = (FillW + 1)'(PACK);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                    r_state;
    logic [ADDR_WIDTH-1:0]     r_base;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_issued;
    logic [1:0]                r_vld;
    logic [FillW-1:0]          r_fill;
    logic [PACK*OUT_WIDTH-1:0] r_lanes;
    logic [PACK*OUT_WIDTH-1:0] r_out_data;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic                      r_busy;
    logic                      r_done;

    logic [FillW:0] w_used;
    logic           w_rd_en;
    logic           w_final;
    logic           w_word_rdy;
    logic           w_xfer;

    // Credit: reads in flight plus filled lanes never exceed one word.
    assign w_used     = (FillW + 1)'(r_fill) + (FillW + 1)'(r_vld[0]) + (FillW + 1)'(r_vld[1]);
    assign w_rd_en    = (r_state == StRun) && (r_issued != r_len) && (w_used < PackU);
    assign w_final    = (r_issued == r_len) && (r_vld == 2'b00);
    assign w_word_rdy = (r_fill == PackF) || (w_final && (r_fill != '0));
    assign w_xfer     = w_word_rdy && (!r_out_valid || out_ready);

    assign psum_rd_en   = w_rd_en;
    assign psum_rd_addr = r_base + ADDR_WIDTH'(r_issued);
    assign relu_ifm     = psum_rd_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_vld       <= '0;
            r_fill      <= '0;
            r_lanes     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= {r_vld[0], w_rd_en};
            if (w_rd_en) begin
                r_issued <= r_issued + LEN_WIDTH'(1);
            end

            // Credit guarantees a capture never coincides with a full-lane transfer.
            if (w_xfer) begin
                r_lanes <= '0;
                r_fill  <= '0;
            end else if (r_vld[1]) begin
                for (int k = 0; k < PACK; k++) begin
                    if (r_fill == FillW'(k)) begin
                        r_lanes[k*OUT_WIDTH +: OUT_WIDTH] <= relu_ofm;
                    end
                end
                r_fill <= r_fill + FillW'(1);
            end

            if (w_xfer) begin
                r_out_data  <= r_lanes;
                r_out_valid <= 1'b1;
                r_out_last  <= w_final;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_len    <= len;
                        r_issued <= '0;
                        r_busy   <= 1'b1;
                        if (len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (w_rd_en && (r_issued == r_len - LEN_WIDTH'(1))) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_out_valid && r_out_last && out_ready) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_drain_ctrl.sv
// Directed bench for relu_drain_ctrl with a psum memory and ReLU/requant stub
// (ReLU, round-shift by 9, saturate to 127).
module tb_relu_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        busy, done, psum_rd_en;
    logic [9:0]  psum_rd_addr;
    logic [25:0] psum_rd_data;
    logic [25:0] relu_ifm;
    logic [7:0]  relu_ofm;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;

    logic [25:0] mem [1024];
    int total = 0;
    int bad = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic [9:0]  q_addr[$];
    int rd_cnt, done_cyc, done_cnt, busy_cnt, stab_err, rd_at_rel, last_hs, ov_cnt;

    always #5 clk = ~clk;

    relu_drain_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .psum_rd_en   (psum_rd_en),
        .psum_rd_addr (psum_rd_addr),
        .psum_rd_data (psum_rd_data),
        .relu_ifm     (relu_ifm),
        .relu_ofm     (relu_ofm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    function automatic logic [7:0] relu_f(input logic [25:0] x);
        logic [26:0] t;
        if (x[25]) return 8'h00;
        t = ({1'b0, x} + 27'd256) >> 9;
        if (t > 27'd127) return 8'h7F;
        return t[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_rd_data <= '0;
            relu_ofm     <= '0;
        end else begin
            if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];
            relu_ofm <= relu_f(relu_ifm);
        end
    end

    // Runs one tile; optional stall after first out_valid and optional stray start.
    task automatic run_tile(input logic [9:0] b, input logic [10:0] n,
                            input int stall_len, input int inj_cycle);
        int  stall_left;
        bit  armed;
        bit  prev_hold;
        logic [31:0] prev_data;
        logic        prev_last;
        stall_left = 0; armed = 0; prev_hold = 0; prev_data = '0; prev_last = 0;
        q_data.delete(); q_last.delete(); q_addr.delete();
        rd_cnt = 0; done_cyc = -1; done_cnt = 0; busy_cnt = 0; stab_err = 0;
        rd_at_rel = -1; last_hs = -1; ov_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n; out_ready = 1'b1;
        for (int c = 1; c < 150; c++) begin
            @(posedge clk); #1;
            start = (c == inj_cycle);
            if (c == inj_cycle) begin
                base_addr = 10'h000;
                len = 11'd5;
            end
            if (prev_hold && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stab_err++;
            if (!armed && out_valid && stall_len > 0) begin
                armed = 1;
                stall_left = stall_len;
            end
            out_ready = (stall_left == 0);
            if (psum_rd_en) begin
                rd_cnt++;
                q_addr.push_back(psum_rd_addr);
            end
            if (busy) busy_cnt++;
            if (out_valid) ov_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                last_hs = c;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) rd_at_rel = rd_cnt;
            end
            if (done_cyc >= 0 && c > done_cyc + 3) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (psum_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", psum_rd_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (psum_rd_addr !== 10'h0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", psum_rd_addr); end
    endtask

    task automatic test_one_word();
        mem[0] = 26'h3FFFFFB; mem[1] = 26'h0000200; mem[2] = 26'h00001FF; mem[3] = 26'h0FFFFFF;
        run_tile(10'h000, 11'd4, 0, -1);
        total++; if (q_data.size() != 1) begin bad++; $display("FAIL t1_words got=%0d exp=1", q_data.size()); end
        else begin
            total++; if (q_data[0] !== 32'h7F010100) begin bad++; $display("FAIL t1_data got=%h exp=7f010100", q_data[0]); end
            total++; if (q_last[0] !== 1'b1) begin bad++; $display("FAIL t1_last got=%b exp=1", q_last[0]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL t1_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL t1_done_time got=%0d exp=%0d", done_cyc, last_hs + 1); end
        total++; if (rd_cnt != 4) begin bad++; $display("FAIL t1_reads got=%0d exp=4", rd_cnt); end
    endtask

    task automatic test_partial_word();
        for (int i = 0; i < 6; i++) mem[10'h020 + i] = 26'(i + 1) << 9;
        run_tile(10'h020, 11'd6, 0, -1);
        total++; if (q_data.size() != 2) begin bad++; $display("FAIL t2_words got=%0d exp=2", q_data.size()); end
        else begin
            total++; if (q_data[0] !== 32'h04030201 || q_last[0] !== 1'b0) begin bad++;
                $display("FAIL t2_word0 got=%h/%b exp=04030201/0", q_data[0], q_last[0]); end
            total++; if (q_data[1] !== 32'h00000605 || q_last[1] !== 1'b1) begin bad++;
                $display("FAIL t2_word1 got=%h/%b exp=00000605/1", q_data[1], q_last[1]); end
        end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL t2_done_time got=%0d exp=%0d", done_cyc, last_hs + 1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09; exp_w[3] = 32'h100F0E0D;
        for (int i = 0; i < 16; i++) mem[10'h100 + i] = 26'(i + 1) << 9;
        run_tile(10'h100, 11'd16, 20, -1);
        total++; if (stab_err != 0) begin bad++; $display("FAIL t3_stable got=%0d exp=0", stab_err); end
        total++; if (rd_at_rel != 8) begin bad++; $display("FAIL t3_credit_reads got=%0d exp=8", rd_at_rel); end
        total++; if (q_data.size() != 4) begin bad++; $display("FAIL t3_words got=%0d exp=4", q_data.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (q_data[i] !== exp_w[i] || q_last[i] !== (i == 3)) begin bad++;
                    $display("FAIL t3_word%0d got=%h/%b exp=%h/%b", i, q_data[i], q_last[i], exp_w[i], i == 3); end
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL t3_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_empty_tile();
        run_tile(10'h000, 11'd0, 0, -1);
        total++; if (done_cyc != 1) begin bad++; $display("FAIL t4_done_time got=%0d exp=1", done_cyc); end
        total++; if (busy_cnt != 1) begin bad++; $display("FAIL t4_busy_cycles got=%0d exp=1", busy_cnt); end
        total++; if (rd_cnt != 0) begin bad++; $display("FAIL t4_reads got=%0d exp=0", rd_cnt); end
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL t4_out_valid got=%0d exp=0", ov_cnt); end
    endtask

    task automatic test_wrap_ignored_start();
        mem[10'h3FE] = 26'h0A << 9; mem[10'h3FF] = 26'h0B << 9;
        mem[10'h000] = 26'h0C << 9; mem[10'h001] = 26'h0D << 9;
        run_tile(10'h3FE, 11'd4, 0, 3);
        total++; if (q_addr.size() != 4) begin bad++; $display("FAIL t5_reads got=%0d exp=4", q_addr.size()); end
        else begin
            total++; if (q_addr[0] !== 10'h3FE || q_addr[1] !== 10'h3FF || q_addr[2] !== 10'h000
                         || q_addr[3] !== 10'h001) begin bad++;
                $display("FAIL t5_addrs got=%h,%h,%h,%h exp=3fe,3ff,000,001",
                         q_addr[0], q_addr[1], q_addr[2], q_addr[3]); end
        end
        total++; if (q_data.size() != 1) begin bad++; $display("FAIL t5_words got=%0d exp=1", q_data.size()); end
        else begin
            total++; if (q_data[0] !== 32'h0D0C0B0A) begin bad++; $display("FAIL t5_data got=%h exp=0d0c0b0a", q_data[0]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL t5_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_tile();
        int seen_done;
        seen_done = 0;
        for (int i = 0; i < 16; i++) mem[10'h200 + i] = 26'(i + 1) << 9;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h200; len = 11'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || psum_rd_en !== 1'b0) begin bad++;
            $display("FAIL t6_ctrl got=busy%b done%b rd%b exp=000", busy, done, psum_rd_en); end
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0 || psum_rd_addr !== 10'h0)
            begin bad++; $display("FAIL t6_data got=v%b l%b d%h a%h exp=all0", out_valid, out_last, out_data,
                                  psum_rd_addr); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        total++; if (seen_done != 0) begin bad++; $display("FAIL t6_no_done got=%0d exp=0", seen_done); end
        mem[0] = 26'h3FFFFFB; mem[1] = 26'h0000200; mem[2] = 26'h00001FF; mem[3] = 26'h0FFFFFF;
        run_tile(10'h000, 11'd4, 0, -1);
        total++; if (q_data.size() != 1 || q_data[0] !== 32'h7F010100 || done_cnt != 1) begin bad++;
            $display("FAIL t6_after got=n%0d done%0d exp=n1 7f010100 done1", q_data.size(), done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1;
        test_reset();
        #20 rst_n = 1'b1;
        test_one_word();
        test_partial_word();
        test_backpressure();
        test_empty_tile();
        test_wrap_ignored_start();
        test_reset_mid_tile();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
